i2c_bit_engine: RTL and testbench
=================================

I2C_BIT_ENGINE -- requirements
Module: i2c_bit_engine

Interface
REQ-001 SHALL have parameter SCL_HALF, default 4, I2C_clk cycles per SCL half-period (legal range 2..255).
REQ-002 SHALL have port I2C_clk  input  1  clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port write  input  1  operand capture strobe.
REQ-005 SHALL have port dev_addr  input  7  slave device address.
REQ-006 SHALL have port sub_addr  input  16  register sub-address, high byte sent first.
REQ-007 SHALL have port wr_data  input  8  data byte to write.
REQ-008 SHALL have port sel  input  3  SDA source select from the write controller.
REQ-009 SHALL have port SclEn  input  1  SCL toggling enable.
REQ-010 SHALL have port SetCountMax  input  1  bit-counter preload strobe.
REQ-011 SHALL have port SCL  output  1  SCL level; 1 = released.
REQ-012 SHALL have port SDA_oe  output  1  open-drain SDA pull-down; 1 = drive low, 0 = release.
REQ-013 SHALL have port LastData  output  1  current byte fully clocked out.

Function
REQ-014 SHALL capture dev_addr, sub_addr and wr_data into internal registers when write=1 and SclEn=0; write SHALL be ignored while SclEn=1.
REQ-015 SHALL form four bytes: sel=2 {dev_addr,1'b0}, sel=3 sub_addr[15:8], sel=4 sub_addr[7:0], sel=5 wr_data.
REQ-016 SCL divider: while SclEn=0, divcnt=0 and SCL=1 from the next cycle.
REQ-017 SCL divider: while SclEn=1, divcnt SHALL increment each cycle; at SCL_HALF-1 it SHALL wrap to 0 and SCL SHALL toggle in the same cycle.
REQ-018 First SCL fall SHALL occur SCL_HALF cycles after SclEn rises; period SHALL be 2*SCL_HALF.
REQ-019 Bit counter bitcnt (3 bits) and flag done: SetCountMax=1 SHALL load bitcnt=7 and clear done.
REQ-020 On each SCL 1->0 toggle with sel in 2..5: if bitcnt!=0 SHALL decrement bitcnt, otherwise SHALL set done.
REQ-021 SetCountMax SHALL win over a coincident falling edge.
REQ-022 LastData SHALL equal done (registered).
REQ-023 SDA_oe SHALL be registered, one-cycle latency from sel/bitcnt: sel=0 -> 1; sel=1 -> 0; sel 2..5 -> ~byte[bitcnt]; sel 6,7 -> 0.
REQ-024 bitcnt SHALL change only on SCL falling edges, so SDA changes only while SCL is low (or SCL disabled).
REQ-025 After done=1, further falling edges SHALL hold bitcnt=0 and done=1 until SetCountMax.
REQ-026 SclEn deasserted mid-half-period SHALL force SCL=1 and divcnt=0 on the next cycle; bitcnt and done SHALL be held.

Reset
REQ-027 On reset=1 at a clock edge: SCL=1, SDA_oe=0, LastData=0, done=0, bitcnt=7, divcnt=0, operand registers=0.
REQ-028 Reset SHALL take priority over all inputs, including mid-byte.

Configuration
REQ-029 With macro I2C_CLK_STRETCH_EN defined, the module SHALL have input SCL_in (1 bit, bus SCL level).
REQ-030 With I2C_CLK_STRETCH_EN defined: while SCL=1 and SCL_in=0, divcnt SHALL freeze, extending the high phase until SCL_in=1.
REQ-031 With I2C_CLK_STRETCH_EN undefined, SCL_in and all stretch logic SHALL be absent.

Verification
REQ-032 Reset: assert reset 2 cycles mid-transfer -> next cycle SCL=1, SDA_oe=0, LastData=0.
REQ-033 SCL period: SCL_HALF=4, SclEn=1 for 32 cycles -> SCL falls at cycle 4 and toggles every 4 cycles (4 full periods); SclEn=0 -> SCL=1 next cycle.
REQ-034 Address byte: dev_addr=0x50, write, SetCountMax, sel=2 -> SDA_oe per bit 0,1,0,1,1,1,1,1; LastData=1 after the 8th falling edge.
REQ-035 Data byte: wr_data=0xA5, sel=5 -> SDA_oe 0,1,0,1,1,0,1,0; SetCountMax coincident with a falling edge -> bitcnt=7, LastData=0.
REQ-036 Ignored capture: write pulse with SclEn=1 and wr_data=0xFF -> transmitted byte unchanged.
REQ-037 Clock stretch (I2C_CLK_STRETCH_EN): hold SCL_in=0 for 10 cycles after SCL rises -> SCL high phase is 4+10 cycles; without the macro -> high phase is 4 cycles.

Source files
------------

// File: rtl/i2c_bit_engine.sv
// I2C bit engine: SCL divider, per-byte bit counter and open-drain SDA pull-down.
// Optional clock stretching is enabled by defining I2C_CLK_STRETCH_EN.
module i2c_bit_engine #(
  parameter int unsigned SCL_HALF = 4
) (
  input  logic        I2C_clk,
  input  logic        reset,
  input  logic        write,
  input  logic [6:0]  dev_addr,
  input  logic [15:0] sub_addr,
  input  logic [7:0]  wr_data,
  input  logic [2:0]  sel,
  input  logic        SclEn,
  input  logic        SetCountMax,
`ifdef I2C_CLK_STRETCH_EN
  input  logic        SCL_in,
`endif
  output logic        SCL,
  output logic        SDA_oe,
  output logic        LastData
);

  localparam int unsigned DIV_W = 8;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCL_HALF - 1);

  logic [6:0]       dev_q;
  logic [15:0]      sub_q;
  logic [7:0]       data_q;
  logic [DIV_W-1:0] divcnt;
  logic [2:0]       bitcnt;
  logic             done;

  logic             stall_c;
  logic             fall_c;
  logic             byte_sel_c;
  logic [7:0]       byte_c;
  logic             sda_next_c;

  // A slave holding the bus SCL low while we release it freezes the divider.
`ifdef I2C_CLK_STRETCH_EN
  assign stall_c = SCL & ~SCL_in;
`else
  assign stall_c = 1'b0;
`endif

  assign fall_c = SclEn & ~stall_c & SCL & (divcnt == DIV_LAST);

  // Byte selection and next SDA pull-down value
  always_comb begin
    byte_c     = 8'h00;
    byte_sel_c = 1'b0;
    sda_next_c = 1'b0;
    case (sel)
      3'd2: begin byte_c = {dev_addr_q_c(dev_q), 1'b0}; byte_sel_c = 1'b1; end
      3'd3: begin byte_c = sub_q[15:8];                  byte_sel_c = 1'b1; end
      3'd4: begin byte_c = sub_q[7:0];                   byte_sel_c = 1'b1; end
      3'd5: begin byte_c = data_q;                       byte_sel_c = 1'b1; end
      default: ;
    endcase
    case (sel)
      3'd0:                      sda_next_c = 1'b1;
      3'd2, 3'd3, 3'd4, 3'd5:    sda_next_c = ~byte_c[bitcnt];
      default:                   sda_next_c = 1'b0;
    endcase
  end

  function automatic logic [6:0] dev_addr_q_c(input logic [6:0] a);
    return a;
  endfunction

  always_ff @(posedge I2C_clk) begin
    if (reset) begin
      dev_q  <= 7'd0;
      sub_q  <= 16'd0;
      data_q <= 8'd0;
      divcnt <= '0;
      SCL    <= 1'b1;
      bitcnt <= 3'd7;
      done   <= 1'b0;
      SDA_oe <= 1'b0;
    end else begin
      // Operands only change while the bus clock is idle
      if (write && !SclEn) begin
        dev_q  <= dev_addr;
        sub_q  <= sub_addr;
        data_q <= wr_data;
      end

      if (!SclEn) begin
        divcnt <= '0;
        SCL    <= 1'b1;
      end else if (!stall_c) begin
        if (divcnt == DIV_LAST) begin
          divcnt <= '0;
          SCL    <= ~SCL;
        end else begin
          divcnt <= divcnt + DIV_W'(1);
        end
      end

      // Preload wins over a coincident falling edge
      if (SetCountMax) begin
        bitcnt <= 3'd7;
        done   <= 1'b0;
      end else if (fall_c && byte_sel_c) begin
        if (bitcnt != 3'd0) bitcnt <= bitcnt - 3'd1;
        else                done   <= 1'b1;
      end

      SDA_oe <= sda_next_c;
    end
  end

  assign LastData = done;

endmodule

// File: tb/tb_i2c_bit_engine.sv
// Randomized self-checking bench for i2c_bit_engine against a cycle-count arithmetic model.
module tb_i2c_bit_engine;

  localparam int H = 4;

  logic        I2C_clk = 1'b0;
  logic        reset = 1'b1;
  logic        write = 1'b0;
  logic [6:0]  dev_addr = 7'd0;
  logic [15:0] sub_addr = 16'd0;
  logic [7:0]  wr_data = 8'd0;
  logic [2:0]  sel = 3'd0;
  logic        SclEn = 1'b0;
  logic        SetCountMax = 1'b0;
  logic        SCL_in = 1'b1;
  logic        SCL, SDA_oe, LastData;

  int checks = 0;
  int errors = 0;

  logic [6:0]  m_dev = 7'd0;
  logic [15:0] m_sub = 16'd0;
  logic [7:0]  m_data = 8'd0;

  i2c_bit_engine #(.SCL_HALF(H)) dut (
    .I2C_clk(I2C_clk), .reset(reset), .write(write), .dev_addr(dev_addr),
    .sub_addr(sub_addr), .wr_data(wr_data), .sel(sel), .SclEn(SclEn),
    .SetCountMax(SetCountMax),
`ifdef I2C_CLK_STRETCH_EN
    .SCL_in(SCL_in),
`endif
    .SCL(SCL), .SDA_oe(SDA_oe), .LastData(LastData)
  );

  always #5 I2C_clk = ~I2C_clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge I2C_clk);
    #1;
  endtask

  // Falling edges seen after n enabled cycles: they land at n = H, 3H, 5H, ...
  function automatic int falls(input int n);
    return (n + H) / (2 * H);
  endfunction

  function automatic logic [7:0] model_byte(input logic [2:0] s);
    case (s)
      3'd2:    return {m_dev, 1'b0};
      3'd3:    return m_sub[15:8];
      3'd4:    return m_sub[7:0];
      default: return m_data;
    endcase
  endfunction

  function automatic logic model_sda(input logic [7:0] b, input int f);
    int idx;
    idx = (f >= 7) ? 0 : 7 - f;
    return ~b[idx];
  endfunction

  task automatic load(input logic [6:0] d, input logic [15:0] s, input logic [7:0] w);
    dev_addr = d; sub_addr = s; wr_data = w; write = 1'b1;
    tick();
    write = 1'b0;
    m_dev = d; m_sub = s; m_data = w;
  endtask

  task automatic preload(input logic [2:0] s);
    SclEn = 1'b0; sel = s; SetCountMax = 1'b1;
    tick();
    SetCountMax = 1'b0;
    tick();
  endtask

  // Clock one byte out and compare SCL, SDA_oe, LastData every cycle.
  task automatic run_byte(input logic [2:0] s, input bit poke_write);
    logic [7:0] b;
    b = model_byte(s);
    preload(s);
    check("sda_first", {7'd0, SDA_oe}, {7'd0, ~b[7]});
    SclEn = 1'b1;
    for (int n = 1; n <= 16 * H + 2; n++) begin
      tick();
      check("scl", {7'd0, SCL}, {7'd0, 1'(((n / H) % 2) == 0)});
      check("sda", {7'd0, SDA_oe}, {7'd0, model_sda(b, falls(n - 1))});
      check("last", {7'd0, LastData}, {7'd0, 1'(falls(n) >= 8)});
      if (poke_write && n == 5) begin
        wr_data = 8'hFF; write = 1'b1;
      end else begin
        write = 1'b0;
        wr_data = m_data;
      end
    end
    SclEn = 1'b0;
    tick();
    check("scl_idle", {7'd0, SCL}, 8'd1);
    check("last_hold", {7'd0, LastData}, 8'd1);
  endtask

  task automatic wait_scl(input logic lvl);
    int k;
    k = 0;
    while (SCL !== lvl && k < 64) begin
      tick();
      k++;
    end
    check("wait_scl", {7'd0, SCL}, {7'd0, lvl});
  endtask

  initial begin
    int hi;
    logic [7:0] b;

    // Reset state
    tick(); tick();
    check("rst_scl", {7'd0, SCL}, 8'd1);
    check("rst_sda", {7'd0, SDA_oe}, 8'd0);
    check("rst_last", {7'd0, LastData}, 8'd0);
    reset = 1'b0;

    // Static SDA sources
    sel = 3'd0; tick(); check("sel0", {7'd0, SDA_oe}, 8'd1);
    sel = 3'd1; tick(); check("sel1", {7'd0, SDA_oe}, 8'd0);
    sel = 3'd6; tick(); check("sel6", {7'd0, SDA_oe}, 8'd0);
    sel = 3'd7; tick(); check("sel7", {7'd0, SDA_oe}, 8'd0);

    // Directed address and data bytes
    load(7'h50, 16'h1234, 8'hA5);
    run_byte(3'd2, 1'b0);
    run_byte(3'd5, 1'b1);

    // Randomized operands across every byte source
    for (int r = 0; r < 3; r++) begin
      for (int s = 2; s <= 5; s++) begin
        load(7'($urandom), 16'($urandom), 8'($urandom));
        run_byte(3'(s), (s == 5));
      end
    end

    // Preload coinciding with the third falling edge (n = 5H)
    load(7'h11, 16'h2233, 8'hA5);
    preload(3'd5);
    SclEn = 1'b1;
    for (int n = 1; n <= 5 * H + 1; n++) begin
      if (n == 5 * H) SetCountMax = 1'b1;
      tick();
      SetCountMax = 1'b0;
      if (n == 5 * H) begin
        check("coinc_scl", {7'd0, SCL}, 8'd0);
        check("coinc_last", {7'd0, LastData}, 8'd0);
      end
    end
    check("coinc_sda", {7'd0, SDA_oe}, {7'd0, ~m_data[7]});
    SclEn = 1'b0;
    tick();

    // Reset mid-transfer
    load(7'h7F, 16'hFFFF, 8'hFF);
    preload(3'd2);
    SclEn = 1'b1;
    for (int n = 0; n < 2 * H + 1; n++) tick();
    reset = 1'b1;
    tick();
    check("mid_rst_scl", {7'd0, SCL}, 8'd1);
    check("mid_rst_sda", {7'd0, SDA_oe}, 8'd0);
    check("mid_rst_last", {7'd0, LastData}, 8'd0);
    tick();
    check("mid_rst_sda2", {7'd0, SDA_oe}, 8'd0);
    reset = 1'b0; SclEn = 1'b0; sel = 3'd5;
    m_dev = 7'd0; m_sub = 16'd0; m_data = 8'd0;
    tick();
    check("rst_operand", {7'd0, SDA_oe}, 8'd1);
    check("rst_last2", {7'd0, LastData}, 8'd0);

    // High-phase length, optionally stretched by the slave
    load(7'h2A, 16'h0000, 8'h00);
    b = model_byte(3'd2);
    preload(3'd2);
    check("str_sda", {7'd0, SDA_oe}, {7'd0, ~b[7]});
    SclEn = 1'b1;
    wait_scl(1'b0);
    wait_scl(1'b1);
`ifdef I2C_CLK_STRETCH_EN
    SCL_in = 1'b0;
`endif
    hi = 1;
    for (int j = 1; j < 64; j++) begin
      tick();
      if (j == 10) SCL_in = 1'b1;
      if (SCL !== 1'b1) break;
      hi++;
    end
`ifdef I2C_CLK_STRETCH_EN
    check("high_phase", 8'(hi), 8'(H + 10));
`else
    check("high_phase", 8'(hi), 8'(H));
`endif
    SclEn = 1'b0;
    tick();
    check("scl_off", {7'd0, SCL}, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
